// File: rtl/exe_stage.sv
// Execute stage: single-cycle move/add/sub/nop, iterative shift-add multiply,
// valid/allowin handshake toward write-back.
module exe_stage #(
  parameter int MUL_CYCLES = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ds_to_es_valid,
  input  logic [27:0] ds_to_es_bus,
  input  logic [1:0]  ds_dest,
  output logic        es_allowin,
  input  logic        ws_allowin,
  output logic        es_to_ws_valid,
  output logic [18:0] es_to_ws_bus,
  output logic        es_busy
);

  localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  localparam logic [3:0] OP_MOV = 4'b1000;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_MUL = 4'b0001;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t        r_state, w_state_nxt;
  logic          r_es_valid;
  logic [3:0]    r_op;
  logic [7:0]    r_rx, r_ry, r_pc;
  logic [1:0]    r_dest;
  logic [7:0]    r_acc, r_mcand, r_mplier;
  logic [CW-1:0] r_cnt;

  logic          w_ready_go;
  logic          w_capture;
  logic          w_leave;
  logic          w_ds_is_mul;
  logic          w_mul_last;
  logic [7:0]    w_result;
  logic          w_wen;

  assign w_ds_is_mul    = (ds_to_es_bus[27:24] == OP_MUL);
  assign w_mul_last     = (r_cnt == CW'(MUL_CYCLES - 1));
  assign es_allowin     = !r_es_valid || (w_ready_go && ws_allowin);
  assign w_capture      = ds_to_es_valid && es_allowin;
  assign es_to_ws_valid = r_es_valid && w_ready_go;
  assign w_leave        = es_to_ws_valid && ws_allowin;

  // Multiply FSM state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Multiply FSM next-state; a mul captured on the leave edge restarts CALC directly
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_capture && w_ds_is_mul) w_state_nxt = S_CALC;
      S_CALC: if (w_mul_last)               w_state_nxt = S_DONE;
      S_DONE: if (w_leave)
                w_state_nxt = (w_capture && w_ds_is_mul) ? S_CALC : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Multiply FSM outputs: stall only while iterating
  always_comb begin
    w_ready_go = (r_state != S_CALC);
    es_busy    = (r_state == S_CALC);
  end

  // Stage valid bit: refreshed whenever the stage is able to accept
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)         r_es_valid <= 1'b0;
    else if (es_allowin) r_es_valid <= ds_to_es_valid;
  end

  // Operand latch on capture, shift-add iteration while in CALC
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_op     <= '0;
      r_rx     <= '0;
      r_ry     <= '0;
      r_pc     <= '0;
      r_dest   <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else if (w_capture) begin
      r_op   <= ds_to_es_bus[27:24];
      r_ry   <= ds_to_es_bus[23:16];
      r_rx   <= ds_to_es_bus[15:8];
      r_pc   <= ds_to_es_bus[7:0];
      r_dest <= ds_dest;
      if (w_ds_is_mul) begin
        r_acc    <= '0;
        r_mcand  <= ds_to_es_bus[15:8];
        r_mplier <= ds_to_es_bus[23:16];
        r_cnt    <= '0;
      end
    end else if (r_state == S_CALC) begin
      if (r_mplier[0]) r_acc <= r_acc + r_mcand;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 1'b1;
    end
  end

  // Result select; non-one-hot ops behave as a nop with no register write
  always_comb begin
    w_result = '0;
    w_wen    = 1'b1;
    case (r_op)
      OP_MOV:  w_result = r_ry;
      OP_ADD:  w_result = r_rx + r_ry;
      OP_SUB:  w_result = r_rx - r_ry;
      OP_MUL:  w_result = r_acc;
      default: w_wen    = 1'b0;
    endcase
  end

  // Bus is zero whenever nothing is being offered to write-back
  always_comb begin
    es_to_ws_bus = '0;
    if (es_to_ws_valid) es_to_ws_bus = {w_wen, r_dest, w_result, r_pc};
  end

endmodule
